// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared read-owner type and default widths for the data memory arbiter
package data_memory_arbiter_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_AUX} owner_e;
  localparam int DM_V = 256;
  localparam int DM_AW = 14;
  localparam int DM_BE = 32;
endpackage

// File: rtl/dm_arb_select.sv
// dm_arb_select: core/aux grant selection (fixed priority + starvation guard, or round-robin under DATA_MEMORY_ARBITER_RR_EN); ports clk, rst, c_req, a_req -> c_gnt, a_gnt
module dm_arb_select #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic a_req,
  output logic c_gnt,
  output logic a_gnt
);
`ifdef DATA_MEMORY_ARBITER_RR_EN
  // r_last = 1 means aux won the most recent grant, so core wins the next contention
  logic r_last;
  always_comb begin
    c_gnt = !rst & c_req & (!a_req | r_last);
    a_gnt = !rst & a_req & (!c_req | !r_last);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last <= 1'b1;
    else if (c_gnt | a_gnt) r_last <= a_gnt;
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0] r_starve;
  logic          w_force;
  always_comb begin
    w_force = r_starve == SMAX;
    c_gnt   = !rst & c_req & !(a_req & w_force);
    a_gnt   = !rst & a_req & (!c_req | w_force);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_starve <= '0;
    else r_starve <= (a_req & !a_gnt) ? (w_force ? SMAX : r_starve + 1'b1) : '0;
`endif
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one single-port data memory between core and aux; drives mem_* from the winner and routes 1-cycle read data back to its owner (macro DATA_MEMORY_ARBITER_RR_EN selects round-robin)
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int V          = DM_V,
  parameter int AW         = DM_AW,
  parameter int BE         = V / 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [BE-1:0] c_byteena,
  input  logic [V-1:0]  c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [V-1:0]  c_rdata,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [BE-1:0] a_byteena,
  input  logic [V-1:0]  a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [V-1:0]  a_rdata,
  output logic [AW-1:0] mem_address,
  output logic [BE-1:0] mem_byteena,
  output logic [V-1:0]  mem_write_data,
  output logic          mem_rden,
  output logic          mem_wren,
  input  logic [V-1:0]  mem_read_data
);
  owner_e r_owner;
  logic   w_we;
  dm_arb_select #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk  (clk),
    .rst  (rst),
    .c_req(c_req),
    .a_req(a_req),
    .c_gnt(c_gnt),
    .a_gnt(a_gnt)
  );
  always_comb begin
    w_we           = c_gnt ? c_we : a_gnt & a_we;
    mem_address    = c_gnt ? c_addr : a_gnt ? a_addr : '0;
    mem_byteena    = c_gnt ? c_byteena : a_gnt ? a_byteena : '0;
    mem_write_data = c_gnt ? c_wdata : a_gnt ? a_wdata : '0;
    mem_wren       = w_we;
    mem_rden       = (c_gnt | a_gnt) & !w_we;
    c_rvalid       = r_owner == OWN_CORE;
    a_rvalid       = r_owner == OWN_AUX;
    c_rdata        = c_rvalid ? mem_read_data : '0;
    a_rdata        = a_rvalid ? mem_read_data : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_owner <= OWN_NONE;
    else r_owner <= !mem_rden ? OWN_NONE : c_gnt ? OWN_CORE : OWN_AUX;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed scoreboard bench for data_memory_arbiter with a behavioural synchronous memory
module tb_data_memory_arbiter;
  logic         clk = 0;
  logic         rst;
  logic         c_req, c_we, a_req, a_we;
  logic [13:0]  c_addr, a_addr;
  logic [31:0]  c_byteena, a_byteena;
  logic [255:0] c_wdata, a_wdata;
  logic         c_gnt, c_rvalid, a_gnt, a_rvalid;
  logic [255:0] c_rdata, a_rdata;
  logic [13:0]  mem_address;
  logic [31:0]  mem_byteena;
  logic [255:0] mem_write_data, mem_read_data;
  logic         mem_rden, mem_wren;

  typedef struct {bit aux; logic [255:0] d;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  logic [255:0] mem [256];
  logic [6:0] exp_a;

  data_memory_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_byteena(c_byteena), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_byteena(a_byteena), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_write_data(mem_write_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rden) mem_read_data <= mem[mem_address[7:0]];
    if (mem_wren)
      for (int b = 0; b < 32; b++)
        if (mem_byteena[b]) mem[mem_address[7:0]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
  end

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  always @(negedge clk)
    if (c_rvalid || a_rvalid) begin
      checks++;
      if (c_rvalid && a_rvalid) begin
        failures++;
        $display("FAIL both_rvalid: got c=1 a=1 expected at most one");
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid: got c=%0b a=%0b expected none", c_rvalid, a_rvalid);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_port", {255'd0, a_rvalid}, {255'd0, mon_e.aux});
        chk("rdata", a_rvalid ? a_rdata : c_rdata, mon_e.d);
        chk("other_rdata_zero", a_rvalid ? c_rdata : a_rdata, '0);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_read_data = '0;
    rst = 1;
    {c_req, c_we, a_req, a_we} = '0;
    c_addr = '0; a_addr = '0; c_byteena = '0; a_byteena = '0; c_wdata = '0; a_wdata = '0;
    @(negedge clk);
    chk("reset_c_gnt", c_gnt, 0);
    chk("reset_a_gnt", a_gnt, 0);
    chk("reset_c_rvalid", c_rvalid, 0);
    chk("reset_a_rvalid", a_rvalid, 0);
    step();
    rst = 0;
    // aux read granted, then reset before the data returns
    a_req = 1; a_we = 0; a_addr = 14'h0010; a_byteena = '1;
    @(negedge clk);
    chk("rst_read_a_gnt", a_gnt, 1);
    chk("rst_read_rden", mem_rden, 1);
    step();
    rst = 1;
    @(negedge clk);
    chk("rst_mid_a_rvalid", a_rvalid, 0);
    chk("rst_mid_c_rvalid", c_rvalid, 0);
    chk("rst_mid_a_gnt", a_gnt, 0);
    chk("rst_mid_rden", mem_rden, 0);
    chk("rst_mid_wren", mem_wren, 0);
    chk("rst_mid_addr", mem_address, 0);
    chk("rst_mid_be", mem_byteena, 0);
    step();
    rst = 0; a_req = 0;
    @(negedge clk);
    chk("rst_after_a_rvalid", a_rvalid, 0);
    // core write then read of 0x0003
    step();
    c_req = 1; c_we = 1; c_addr = 14'h0003; c_byteena = '1; c_wdata = {32{8'hA5}};
    @(negedge clk);
    chk("core_wr_gnt", c_gnt, 1);
    chk("core_wr_wren", mem_wren, 1);
    chk("core_wr_rden", mem_rden, 0);
    chk("core_wr_addr", mem_address, 14'h0003);
    chk("core_wr_data", mem_write_data, {32{8'hA5}});
    step();
    c_we = 0; c_wdata = '0;
    sb.push_back('{0, {32{8'hA5}}});
    @(negedge clk);
    chk("core_rd_gnt", c_gnt, 1);
    chk("core_rd_rden", mem_rden, 1);
    chk("core_wr_no_rvalid", c_rvalid, 0);
    step();
    c_req = 0;
    @(negedge clk);
    chk("core_rd_rvalid", c_rvalid, 1);
    chk("core_rd_a_rvalid", a_rvalid, 0);
    // preload 1 and 2, then alternating back-to-back reads
    step();
    c_req = 1; c_we = 1; c_addr = 14'h0001; c_wdata = {32{8'h11}};
    step();
    c_addr = 14'h0002; c_wdata = {32{8'h22}};
    step();
    c_we = 0; c_addr = 14'h0001; c_wdata = '0;
    sb.push_back('{0, {32{8'h11}}});
    step();
    c_req = 0;
    a_req = 1; a_we = 0; a_addr = 14'h0002;
    sb.push_back('{1, {32{8'h22}}});
    @(negedge clk);
    chk("b2b_a_gnt", a_gnt, 1);
    chk("b2b_c_rvalid", c_rvalid, 1);
    step();
    a_req = 0;
    @(negedge clk);
    chk("b2b_a_rvalid", a_rvalid, 1);
    // aux partial write over an all-ones word, then read back
    step();
    a_req = 1; a_we = 1; a_addr = 14'h0007; a_byteena = '1; a_wdata = '1;
    step();
    a_byteena = 32'h0000_0001; a_wdata = {248'd0, 8'h3C};
    @(negedge clk);
    chk("partial_be", mem_byteena, 32'h0000_0001);
    step();
    a_we = 0; a_byteena = '1; a_wdata = '0;
    sb.push_back('{1, {{31{8'hFF}}, 8'h3C}});
    step();
    a_req = 0;
    step();
    step();
    // contention from a fresh reset, both writing
    rst = 1;
    step();
    rst = 0;
    c_req = 1; c_we = 1; c_addr = 14'h0020; c_wdata = '1;
    a_req = 1; a_we = 1; a_addr = 14'h0021; a_wdata = '1;
`ifdef DATA_MEMORY_ARBITER_RR_EN
    exp_a = 7'b0101010;
`else
    exp_a = 7'b0010000;
`endif
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("cont_c_gnt_%0d", i), c_gnt, !exp_a[i]);
      chk($sformatf("cont_a_gnt_%0d", i), a_gnt, exp_a[i]);
      step();
    end
    c_req = 0; a_req = 0;
    @(negedge clk);
    chk("idle_c_gnt", c_gnt, 0);
    chk("idle_a_gnt", a_gnt, 0);
    step();
    step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port 256-bit data memory between two requesters: the pipeline MEM stage (core, via the data aligner) and the auxiliary AES key/block loader (aux).
- Grants at most one access per cycle and drives the memory's address, byteena, data, rden and wren.
- Tracks the one-cycle synchronous read latency and steers returned read data to its owner.
- Fixed core priority, with a starvation guard for aux.

Parameters:
V, 256, data width in bits
AW, 14, word address width
BE, V/8, byte-enable width
STARVE_MAX, 4, consecutive denied aux cycles before aux is forced ahead of core (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
c_req  in  1  core access request
c_we  in  1  core write (1) / read (0)
c_addr  in  AW  core word address
c_byteena  in  BE  core byte enables
c_wdata  in  V  core write data
c_gnt  out  1  core granted this cycle (combinational)
c_rvalid  out  1  core read data valid
c_rdata  out  V  core read data
a_req, a_we, a_addr, a_byteena, a_wdata  in  1/1/AW/BE/V  aux request, same meaning as core
a_gnt, a_rvalid, a_rdata  out  1/1/V  aux grant / read valid / read data
mem_address  out  AW  to data memory address
mem_byteena  out  BE  to data memory byteena
mem_write_data  out  V  to data memory data
mem_rden  out  1  to data memory rden
mem_wren  out  1  to data memory wren
mem_read_data  in  V  from data memory q, valid one cycle after rden

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- On reset: rvalid_owner = NONE, starve_cnt = 0. All registered state clears immediately. c_rvalid and a_rvalid go 0; an in-flight read is dropped and never reported.
- Handshake: a requester holds req and its payload stable until it samples gnt = 1 at a rising edge. The access executes in that same cycle. A requester with gnt = 0 stalls; the core uses !c_gnt & c_req as a stall.
- Grant selection is combinational: at most one of c_gnt / a_gnt is high. gnt is never asserted without the matching req.
  - Only one req: that requester wins.
  - Both req: core wins, unless starve_cnt == STARVE_MAX, in which case aux wins.
- starve_cnt update at each edge:
  - increment when a_req and not a_gnt, saturating at STARVE_MAX;
  - clear when a_gnt, or when a_req is 0.
- Memory drive:
  - Granted request: mem_address/byteena/write_data = winner's payload; mem_wren = winner's we; mem_rden = !we.
  - No grant: all mem_* outputs are 0.
- Read return:
  - On a granted read, register rvalid_owner = winner (CORE/AUX); otherwise register NONE.
  - Next cycle, the owner's rvalid = 1 for exactly one cycle, and its rdata = mem_read_data. The other port's rdata = 0.
  - Back-to-back reads from either port are allowed every cycle (full throughput).
- Writes produce no rvalid.
- A read granted in the cycle after a write to the same address returns the new data; the memory is in-order.
- Latency: write 0 cycles after grant; read data 1 cycle after grant.

Optional Feature:
- Macro: DATA_MEMORY_ARBITER_RR_EN.
- Defined: fair round-robin.
  - A 1-bit last-winner register (reset = AUX, so core wins the first contention).
  - On contention, the requester that did not win last gets the grant.
  - The register updates on every grant.
  - starve_cnt and STARVE_MAX are unused; the parameter is still accepted.
- Undefined: fixed core priority with the starvation guard, as above.

Decomposition:
- Package data_memory_arbiter_pkg:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_CORE, OWN_AUX};
  - localparam defaults DM_V = 256, DM_AW = 14, DM_BE = 32.
- Sub-module dm_arb_select: grant selection plus starve_cnt (or the RR pointer under the macro). Inputs: c_req, a_req, clk, rst. Outputs: c_gnt, a_gnt.
- Top-level: payload mux, mem_* drive and read-return tracking.

Test Plan:
- Reset mid-read: aux read of addr 0x0010 granted, rst pulsed before the next edge -> a_rvalid and c_rvalid stay 0; all mem_* = 0 during rst.
- Core only: write 0xA5 in all bytes to addr 0x0003 (byteena all ones), then read 0x0003 -> c_gnt = 1 both cycles; c_rvalid pulses 1 cycle after the read grant; c_rdata = 0xA5..A5; a_rvalid = 0.
- Contention, fixed priority, STARVE_MAX = 4: both reqs held high from cycle 0 -> core granted cycles 0–3, aux granted cycle 4, core granted cycle 5 onward; starve_cnt 0,1,2,3,4,0.
- Back-to-back alternating reads: core reads 0x0001 (cycle 0), aux reads 0x0002 (cycle 1) -> c_rvalid at cycle 1 with mem[1]; a_rvalid at cycle 2 with mem[2]; never both high.
- Partial write: aux writes byteena = 0x0000_0001, data LSB = 0x3C to 0x0007 holding 0xFF..FF, then reads -> a_rdata = 0xFF..FF3C.
- With DATA_MEMORY_ARBITER_RR_EN, both reqs held high -> grants alternate core, aux, core, aux starting with core.
